atu_handshake: RTL



---
 rtl/atu_pkg.sv | 8 +
 rtl/atu_debounce.sv | 32 +++
 rtl/atu_handshake.sv | 96 +++++++++
 3 files changed

// File: rtl/atu_pkg.sv
// atu_pkg: shared state and status encodings for the antenna tuner handshake
package atu_pkg;
  typedef enum logic [1:0] {IDLE, START, WAIT_ACK, TUNING} atu_state_t;
  localparam logic [1:0] ATU_OK = 2'd0;
  localparam logic [1:0] ATU_ACK_TO = 2'd1;
  localparam logic [1:0] ATU_TUNE_TO = 2'd2;
  localparam logic [1:0] ATU_ABORT = 2'd3;
endpackage

// File: rtl/atu_debounce.sv
// atu_debounce: synchronizes the active-low ack pin and debounces it on ms ticks
module atu_debounce #(
  parameter int DEB_MS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic atu_ack,
  output logic ack_d
);
  localparam int CW = $clog2(DEB_MS + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic ack_s;
  logic hit;
  assign ack_s = ~sync[1];
  assign hit = cnt == CW'(DEB_MS);
  // DEB_MS+1 ticks inside the mismatch window guarantee DEB_MS whole ms of stability
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= 2'b11;
      cnt <= '0;
      ack_d <= 1'b0;
    end else begin
      sync <= {sync[0], atu_ack};
      if (ack_s == ack_d) cnt <= '0;
      else if (tick) begin
        cnt <= hit ? '0 : cnt + 1'b1;
        ack_d <= hit ? ack_s : ack_d;
      end
    end
endmodule

// File: rtl/atu_handshake.sv
// atu_handshake: sequences the antenna tuner request/ack pins and tune carrier
module atu_handshake
  import atu_pkg::*;
#(
  parameter int CLK_KHZ = 76800,
  parameter int REQ_MS = 300,
  parameter int ACK_WAIT_MS = 1000,
  parameter int TUNE_MS = 10000,
  parameter int DEB_MS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tune_start,
  input  logic       tune_abort,
  input  logic       atu_ack,
  output logic       atu_req,
  output logic       tune_carrier,
  output logic       busy,
  output logic       done,
  output logic [1:0] status
);
  localparam int PW = $clog2(CLK_KHZ);
  logic [PW-1:0] pre;
  logic tick;
  logic ack_d;
  logic [15:0] ms;
  atu_state_t state;
  assign tick = pre == PW'(CLK_KHZ - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) pre <= '0;
    else pre <= tick ? '0 : pre + 1'b1;
  atu_debounce #(.DEB_MS(DEB_MS)) u_deb (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .atu_ack(atu_ack),
    .ack_d(ack_d)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      atu_req <= 1'b0;
      tune_carrier <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      status <= ATU_OK;
      ms <= '0;
    end else begin
      done <= 1'b0;
      ms <= (tick && ms != 16'hFFFF) ? ms + 16'd1 : ms;
      if (state != IDLE && tune_abort) begin
        state <= IDLE;
        atu_req <= 1'b0;
        tune_carrier <= 1'b0;
        busy <= 1'b0;
        status <= ATU_ABORT;
        ms <= '0;
      end else
        case (state)
          IDLE:
            if (tune_start) begin
              state <= START;
              atu_req <= 1'b1;
              busy <= 1'b1;
              status <= ATU_OK;
              ms <= '0;
            end
          START:
            if (ms == 16'(REQ_MS)) begin
              state <= WAIT_ACK;
              atu_req <= 1'b0;
              ms <= '0;
            end
          WAIT_ACK:
            if (ack_d) begin
              state <= TUNING;
              tune_carrier <= 1'b1;
              ms <= '0;
            end else if (ms == 16'(ACK_WAIT_MS)) begin
              state <= IDLE;
              busy <= 1'b0;
              status <= ATU_ACK_TO;
              ms <= '0;
            end
          TUNING:
            if (!ack_d || ms == 16'(TUNE_MS)) begin
              state <= IDLE;
              tune_carrier <= 1'b0;
              busy <= 1'b0;
              done <= !ack_d;
              status <= ack_d ? ATU_TUNE_TO : ATU_OK;
              ms <= '0;
            end
        endcase
    end
endmodule
